// File: rtl/demux_pkg.sv
`timescale 1ns/1ps
// Shared channel-select types and constants for the 4-way demux dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;

    typedef logic [CH_W-1:0] ch_sel_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
`timescale 1ns/1ps
// First-available channel search over 4 slots, starting at a given index and wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no slot is available.
module rr_pick4
    import demux_pkg::*;
(
    input  logic [CH_NUM-1:0] avail,
    input  ch_sel_t           start,
    output logic              found,
    output ch_sel_t           idx
);

    ch_sel_t cand;

    // Scan start, start+1, ... (mod 4); the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < CH_NUM; i++) begin
            cand = start + ch_sel_t'(i);
            if (!found && avail[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux4_rr_dispatcher.sv
`timescale 1ns/1ps
// Dispatches a valid/ready input stream to 4 output channels, round-robin or pinned.
// Latency: beat accepted at edge N appears in the channel holding register at edge N.
// Backpressure: in_ready drops only when no eligible channel slot is free or draining.
module demux4_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [1:0]               fixed_sel,
    output logic [4*DATA_W-1:0]      out_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [1:0]               sel,
    output logic [15:0]              beat_cnt
);

    ch_sel_t           ptr;
    ch_sel_t           target;
    logic              target_found;
    logic [CH_NUM-1:0] avail;
    logic              rr_found;
    ch_sel_t           rr_idx;
    logic              accept;

    // A slot can take a beat when empty or when its current beat leaves this cycle.
    assign avail = ~out_valid | out_ready;

    rr_pick4 u_pick (
        .avail (avail),
        .start (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Target channel: fixed mode only ever considers fixed_sel; no dependence on in_valid.
    always_comb begin
        target_found = 1'b0;
        target       = '0;
        if (mode == MODE_FIXED) begin
            target_found = avail[fixed_sel];
            target       = fixed_sel;
        end else begin
            target_found = rr_found;
            target       = rr_idx;
        end
    end

    assign in_ready = target_found;
    assign accept   = in_valid & in_ready;

    // Per-channel holding registers: a reload takes priority over a drain of the same slot.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic              vld_q;
        logic [DATA_W-1:0] dat_q;

        // Load on accept to this channel, otherwise clear valid when downstream takes it.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (accept && (target == ch_sel_t'(k))) begin
                vld_q <= 1'b1;
                dat_q <= in_data;
            end else if (out_ready[k]) begin
                vld_q <= 1'b0;
            end
        end

        assign out_valid[k]                    = vld_q;
        assign out_data[k*DATA_W +: DATA_W]    = dat_q;
    end

    // Bookkeeping: last channel, beat counter, and round-robin pointer (frozen in fixed mode).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel      <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else if (accept) begin
            sel      <= target;
            beat_cnt <= beat_cnt + 16'd1;
            if (mode == MODE_RR) begin
                ptr <= target + ch_sel_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
`timescale 1ns/1ps
// Directed bench for demux4_rr_dispatcher with immediate-assertion checks.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: exercised via out_ready patterns and fixed-mode blocking.
module tb_demux4_rr_dispatcher;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic [1:0]          fixed_sel;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [1:0]          sel;
    logic [15:0]         beat_cnt;

    int checks;
    int errors;

    demux4_rr_dispatcher #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .fixed_sel (fixed_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ch_data(input int ch);
        return out_data[ch*DATA_W +: DATA_W];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Offer one beat expected to be accepted into channel ch.
    task automatic send(input string tag, input logic [7:0] d, input int ch);
        in_data  = d;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        chk({tag, "_sel"}, 32'(sel), 32'(ch));
        chk({tag, "_data"}, 32'(ch_data(ch)), 32'(d));
        chk({tag, "_vld"}, 32'(out_valid[ch]), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        fixed_sel = 2'd0;
        out_ready = 4'hF;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Round-robin, all channels draining: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            send($sformatf("rr%0d", i), 8'(8'h10 + i), i % 4);
            chk($sformatf("rr%0d_onehot", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
        end
        in_valid = 1'b0;
        tick();
        chk("rr_beat_cnt", 32'(beat_cnt), 32'd6);
        chk("rr_drained", 32'(out_valid), 32'h0);

        // Stall skip: ch1 never drains
        do_reset();
        out_ready = 4'b1101;
        send("st0", 8'hA0, 0);
        send("st1", 8'hA1, 1);
        send("st2", 8'hA2, 2);
        send("st3", 8'hA3, 3);
        send("st4", 8'hA4, 0);
        chk("st_ch1_hold_a", 32'(ch_data(1)), 32'hA1);
        send("st5", 8'hA5, 2);
        send("st6", 8'hA6, 3);
        send("st7", 8'hA7, 0);
        in_valid = 1'b0;
        tick();
        chk("st_only_ch1", 32'(out_valid), 32'b0010);
        chk("st_ch1_hold_b", 32'(ch_data(1)), 32'hA1);
        chk("st_beat_cnt", 32'(beat_cnt), 32'd8);
        out_ready = 4'hF;
        tick();
        chk("st_ch1_drained", 32'(out_valid), 32'h0);

        // Full back-pressure, then same-cycle drain and reload of ch2
        do_reset();
        out_ready = 4'h0;
        send("bp0", 8'hB0, 0);
        send("bp1", 8'hB1, 1);
        send("bp2", 8'hB2, 2);
        send("bp3", 8'hB3, 3);
        in_data = 8'hB4;
        #1;
        chk("bp_blocked_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_blocked_vld", 32'(out_valid), 32'hF);
        chk("bp_blocked_cnt", 32'(beat_cnt), 32'd4);
        chk("bp_blocked_ch2", 32'(ch_data(2)), 32'hB2);
        out_ready = 4'b0100;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_reload_ch2", 32'(ch_data(2)), 32'hB4);
        chk("bp_reload_vld", 32'(out_valid), 32'hF);
        chk("bp_reload_sel", 32'(sel), 32'd2);
        chk("bp_reload_cnt", 32'(beat_cnt), 32'd5);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        chk("bp_all_drained", 32'(out_valid), 32'h0);

        // Fixed mode on ch3; ptr stays at 3 (set by the ch2 reload above)
        mode      = 1'b1;
        fixed_sel = 2'd3;
        send("fx0", 8'hC0, 3);
        out_ready = 4'b0111;
        in_data   = 8'hC1;
        #1;
        chk("fx_blocked_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fx_blocked_vld", 32'(out_valid), 32'b1000);
        chk("fx_blocked_ch3", 32'(ch_data(3)), 32'hC0);
        chk("fx_blocked_cnt", 32'(beat_cnt), 32'd6);
        mode      = 1'b0;
        out_ready = 4'hF;
        send("fx_back_rr", 8'hC2, 3);

        // Reset mid-stream with ch0 and ch2 full
        do_reset();
        out_ready = 4'h0;
        mode      = 1'b1;
        fixed_sel = 2'd0;
        send("mr0", 8'hD0, 0);
        fixed_sel = 2'd2;
        send("mr2", 8'hD2, 2);
        mode = 1'b0;
        chk("mr_pre_vld", 32'(out_valid), 32'b0101);
        rst_n   = 1'b0;
        in_data = 8'hD3;
        tick();
        chk("mr_vld", 32'(out_valid), 32'h0);
        chk("mr_sel", 32'(sel), 32'h0);
        chk("mr_cnt", 32'(beat_cnt), 32'h0);
        chk("mr_data0", 32'(ch_data(0)), 32'h0);
        rst_n     = 1'b1;
        out_ready = 4'hF;
        send("mr_next", 8'hD4, 0);

        // Counter wrap: 65535 more beats bring beat_cnt from 1 back to 0
        in_valid = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            in_data = 8'(n);
            tick();
        end
        chk("wrap_cnt", 32'(beat_cnt), 32'h0);
        chk("wrap_sel", 32'(sel), 32'd3);
        send("wrap_next", 8'hE0, 0);
        chk("wrap_cnt_next", 32'(beat_cnt), 32'd1);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
